uart_rx_ctrl: RTL and testbench

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

---
 rtl/uart_rx_ctrl.sv | 158 +++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// 8N1 UART receiver with 16x oversampling; o_valid rises 152*CLKS_PER_OS+3 clocks after the start edge.
// Single-entry output buffer: a byte completing while the buffer is full and not being consumed is dropped and flagged sticky in o_overrun.
module uart_rx_ctrl #(
   parameter int unsigned CLKS_PER_OS = 27
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_rxd,
   input  logic       i_ready,
   input  logic       i_err_clr,
   output logic [7:0] o_data,
   output logic       o_valid,
   output logic       o_frame_err,
   output logic       o_overrun,
   output logic       o_busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_BREAK
   } state_t;

   localparam logic [7:0] PRESC_MAX = 8'(CLKS_PER_OS - 1);

   state_t     state;
   state_t     state_nxt;
   logic       rxd_m;
   logic       rxd_s;
   logic [7:0] presc;
   logic       os_tick;
   logic [3:0] tick_cnt;
   logic [2:0] bit_idx;
   logic [7:0] shift;
   logic       tick_clr;
   logic       shift_en;
   logic       deliver;
   logic       frame_err;

   assign os_tick = (presc == PRESC_MAX);
   assign o_busy  = (state != S_IDLE);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      tick_clr  = 1'b0;
      shift_en  = 1'b0;
      deliver   = 1'b0;
      frame_err = 1'b0;
      case (state)
         S_IDLE: begin
            if (!rxd_s) begin
               state_nxt = S_START;
               tick_clr  = 1'b1;
            end
         end
         S_START: begin
            // mid-point of the start bit: a high line here was only a glitch
            if (os_tick && tick_cnt == 4'd7) begin
               tick_clr  = 1'b1;
               state_nxt = rxd_s ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (os_tick && tick_cnt == 4'd15) begin
               shift_en = 1'b1;
               if (bit_idx == 3'd7) begin
                  state_nxt = S_STOP;
               end
            end
         end
         S_STOP: begin
            if (os_tick && tick_cnt == 4'd15) begin
               if (rxd_s) begin
                  deliver   = 1'b1;
                  state_nxt = S_IDLE;
               end else begin
                  frame_err = 1'b1;
                  state_nxt = S_BREAK;
               end
            end
         end
         S_BREAK: begin
            if (rxd_s) begin
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         rxd_m       <= 1'b1;
         rxd_s       <= 1'b1;
         presc       <= 8'd0;
         tick_cnt    <= 4'd0;
         bit_idx     <= 3'd0;
         shift       <= 8'd0;
         o_data      <= 8'd0;
         o_valid     <= 1'b0;
         o_frame_err <= 1'b0;
         o_overrun   <= 1'b0;
      end else begin
         rxd_m <= i_rxd;
         rxd_s <= rxd_m;

         // held at zero in IDLE so the first tick lands CLKS_PER_OS clocks after START entry
         if (state == S_IDLE || os_tick) begin
            presc <= 8'd0;
         end else begin
            presc <= presc + 8'd1;
         end

         if (state == S_IDLE || tick_clr) begin
            tick_cnt <= 4'd0;
         end else if (os_tick) begin
            tick_cnt <= tick_cnt + 4'd1;
         end

         if (state == S_START) begin
            bit_idx <= 3'd0;
         end else if (shift_en) begin
            bit_idx <= bit_idx + 3'd1;
         end

         if (shift_en) begin
            shift <= {rxd_s, shift[7:1]};
         end

         o_frame_err <= frame_err;

         // a consume and a delivery in the same cycle hand the slot straight to the new byte
         if (deliver && (!o_valid || i_ready)) begin
            o_data  <= shift;
            o_valid <= 1'b1;
         end else if (o_valid && i_ready) begin
            o_valid <= 1'b0;
         end

         if (deliver && o_valid && !i_ready) begin
            o_overrun <= 1'b1;
         end else if (i_err_clr) begin
            o_overrun <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl at CLKS_PER_OS=4 (64-clock bit period).
module tb_uart_rx_ctrl;

   logic       i_clk = 1'b0;
   logic       i_reset = 1'b1;
   logic       i_rxd = 1'b1;
   logic       i_ready = 1'b0;
   logic       i_err_clr = 1'b0;
   logic [7:0] o_data;
   logic       o_valid;
   logic       o_frame_err;
   logic       o_overrun;
   logic       o_busy;

   int n_chk = 0;
   int n_bad = 0;
   int cyc = 0;
   int fe_cnt = 0;
   int vld_cnt = 0;
   logic [8:0] exp_q[$];

   uart_rx_ctrl #(.CLKS_PER_OS(4)) dut (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_rxd      (i_rxd),
      .i_ready    (i_ready),
      .i_err_clr  (i_err_clr),
      .o_data     (o_data),
      .o_valid    (o_valid),
      .o_frame_err(o_frame_err),
      .o_overrun  (o_overrun),
      .o_busy     (o_busy)
   );

   always #5 i_clk = ~i_clk;

   always @(posedge i_clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   // scoreboard: every handshake pops the oldest expected byte
   always @(negedge i_clk) begin
      logic [8:0] exp;
      if (o_frame_err) fe_cnt++;
      if (o_valid) vld_cnt++;
      if (!i_reset && o_valid && i_ready) begin
         exp = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h100;
         check("rx_data", {23'd0, 1'b0, o_data}, {23'd0, exp});
      end
   end

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      @(posedge i_clk);
      #1 i_rxd = 1'b0;
      repeat (64) @(posedge i_clk);
      for (int i = 0; i < 8; i++) begin
         #1 i_rxd = b[i];
         repeat (64) @(posedge i_clk);
      end
      #1 i_rxd = stop_bit;
      repeat (64) @(posedge i_clk);
      #1;
   endtask

   task automatic drain();
      @(posedge i_clk);
      #1 i_ready = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(negedge i_clk);
         if (!o_valid) break;
      end
      check("drain_vld", {31'd0, o_valid}, 32'd0);
      @(posedge i_clk);
      #1 i_ready = 1'b0;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout want completion");
      $display("test done: total=%0d bad=%0d", n_chk, n_bad + 1);
      $fatal(1, "timeout");
   end

   initial begin
      int t0;
      int fe0;
      int v0;
      logic seen;

      // reset state
      repeat (4) @(posedge i_clk);
      @(negedge i_clk);
      check("rst_data", {24'd0, o_data}, 32'h00);
      check("rst_vld", {31'd0, o_valid}, 32'd0);
      check("rst_busy", {31'd0, o_busy}, 32'd0);
      check("rst_fe", {31'd0, o_frame_err}, 32'd0);
      check("rst_ovr", {31'd0, o_overrun}, 32'd0);
      @(posedge i_clk);
      #1 i_reset = 1'b0;
      repeat (5) @(posedge i_clk);

      // clean byte with exact latency
      #1 i_ready = 1'b1;
      exp_q.push_back(9'h0A5);
      fe0 = fe_cnt;
      fork
         send_byte(8'hA5, 1'b1);
         begin
            @(negedge i_rxd);
            t0 = cyc;
            seen = 1'b0;
            for (int k = 0; k < 1000 && !seen; k++) begin
               @(negedge i_clk);
               if (o_valid) seen = 1'b1;
            end
            check("latency", cyc - t0, 611);
            check("a5_data", {24'd0, o_data}, 32'hA5);
            @(negedge i_clk);
            check("a5_one_cycle", {31'd0, o_valid}, 32'd0);
         end
      join
      check("a5_fe", fe_cnt - fe0, 0);
      check("a5_ovr", {31'd0, o_overrun}, 32'd0);
      check("a5_idle", {31'd0, o_busy}, 32'd0);

      // start glitch
      fe0 = fe_cnt;
      v0  = vld_cnt;
      @(posedge i_clk);
      #1 i_rxd = 1'b0;
      repeat (10) @(posedge i_clk);
      @(negedge i_clk);
      check("gl_busy", {31'd0, o_busy}, 32'd1);
      repeat (10) @(posedge i_clk);
      #1 i_rxd = 1'b1;
      repeat (100) @(posedge i_clk);
      @(negedge i_clk);
      check("gl_idle", {31'd0, o_busy}, 32'd0);
      check("gl_vld", vld_cnt - v0, 0);
      check("gl_fe", fe_cnt - fe0, 0);

      // framing error and break
      fe0 = fe_cnt;
      v0  = vld_cnt;
      send_byte(8'h3C, 1'b0);
      repeat (200) @(posedge i_clk);
      @(negedge i_clk);
      check("brk_busy", {31'd0, o_busy}, 32'd1);
      check("brk_fe_cnt", fe_cnt - fe0, 1);
      check("brk_vld", vld_cnt - v0, 0);
      @(posedge i_clk);
      #1 i_rxd = 1'b1;
      repeat (5) @(posedge i_clk);
      @(negedge i_clk);
      check("brk_idle", {31'd0, o_busy}, 32'd0);

      // overrun then clear
      #1 i_ready = 1'b0;
      exp_q.push_back(9'h011);
      send_byte(8'h11, 1'b1);
      send_byte(8'h22, 1'b1);
      @(negedge i_clk);
      check("ovr_data", {24'd0, o_data}, 32'h11);
      check("ovr_vld", {31'd0, o_valid}, 32'd1);
      check("ovr_flag", {31'd0, o_overrun}, 32'd1);
      @(posedge i_clk);
      #1 i_err_clr = 1'b1;
      @(posedge i_clk);
      #1 i_err_clr = 1'b0;
      @(negedge i_clk);
      check("clr_flag", {31'd0, o_overrun}, 32'd0);
      check("clr_data", {24'd0, o_data}, 32'h11);
      drain();

      // consume in the exact delivery cycle
      exp_q.push_back(9'h055);
      send_byte(8'h55, 1'b1);
      @(negedge i_clk);
      check("hold_55", {24'd0, o_data}, 32'h55);
      exp_q.push_back(9'h066);
      fork
         send_byte(8'h66, 1'b1);
         begin
            @(negedge i_rxd);
            repeat (610) @(posedge i_clk);
            #1 i_ready = 1'b1;
            @(posedge i_clk);
            #1 i_ready = 1'b0;
            @(negedge i_clk);
            check("sw_data", {24'd0, o_data}, 32'h66);
            check("sw_vld", {31'd0, o_valid}, 32'd1);
            check("sw_ovr", {31'd0, o_overrun}, 32'd0);
         end
      join
      drain();

      // reset mid-frame, then a clean frame
      v0 = vld_cnt;
      fork
         send_byte(8'hFF, 1'b1);
         begin
            @(negedge i_rxd);
            repeat (352) @(posedge i_clk);
            #1 i_reset = 1'b1;
            repeat (3) @(posedge i_clk);
            @(negedge i_clk);
            check("mr_data", {24'd0, o_data}, 32'h00);
            check("mr_vld", {31'd0, o_valid}, 32'd0);
            check("mr_busy", {31'd0, o_busy}, 32'd0);
            check("mr_fe", {31'd0, o_frame_err}, 32'd0);
            check("mr_ovr", {31'd0, o_overrun}, 32'd0);
            @(posedge i_clk);
            #1 i_reset = 1'b0;
         end
      join
      repeat (10) @(posedge i_clk);
      @(negedge i_clk);
      check("mr_nodeliver", vld_cnt - v0, 0);
      check("mr_idle", {31'd0, o_busy}, 32'd0);
      #1 i_ready = 1'b1;
      exp_q.push_back(9'h081);
      send_byte(8'h81, 1'b1);
      repeat (10) @(posedge i_clk);
      @(negedge i_clk);
      check("q_empty", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
